// File: rtl/adc_pkg.sv
// Shared definitions for the ADC sequencer: one-hot FSM encodings, the default
// calibration channel and a constant-foldable ceil(log2) helper.
package adc_pkg;

  localparam int CAL_CH_DEFAULT = 32'sd0;

  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_PARK    = 5'b00010,
    ST_SETTLE  = 5'b00100,
    ST_CONVERT = 5'b01000,
    ST_SAMPLE  = 5'b10000
  } seq_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 32'sd0;
    while ((32'sd1 << r) < n) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_rr_pick.sv
// Round-robin channel picker: lowest enabled index above the pointer,
// otherwise the lowest enabled index overall.
module adc_rr_pick
  import adc_pkg::*;
#(
  parameter  int NCH = 8,
  localparam int CW  = clog2(NCH)
) (
  input  logic [NCH-1:0] mask_i,
  input  logic [CW-1:0]  ptr_i,
  output logic [CW-1:0]  idx_o,
  output logic           none_o
);

  logic          hi_found_s;
  logic [CW-1:0] hi_idx_s;
  logic [CW-1:0] lo_idx_s;

  // Scan downwards so the lowest matching index is the one that survives.
  always_comb begin
    hi_found_s = 1'b0;
    hi_idx_s   = '0;
    lo_idx_s   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      lo_idx_s   = mask_i[i] ? CW'(i) : lo_idx_s;
      hi_found_s = (mask_i[i] && (i > int'(ptr_i))) ? 1'b1 : hi_found_s;
      hi_idx_s   = (mask_i[i] && (i > int'(ptr_i))) ? CW'(i) : hi_idx_s;
    end
    idx_o  = hi_found_s ? hi_idx_s : lo_idx_s;
    none_o = ~|mask_i;
  end

endmodule

// File: rtl/adc_sequencer.sv
// Round-robin SAR ADC conversion sequencer with park/calibration slot,
// programmable settle delay and channel freeze. All outputs are registered.
module adc_sequencer
  import adc_pkg::*;
#(
  parameter  int NCH    = 8,
  parameter  int DLY_W  = 8,
  parameter  int CAL_CH = CAL_CH_DEFAULT,
  localparam int CW     = clog2(NCH)
) (
  input  logic             SCK,
  input  logic             POR,
  input  logic             sys_ready,
  input  logic [NCH-1:0]   ch_mask,
  input  logic [DLY_W-1:0] settle_cycles,
  input  logic             adc_ready,
  input  logic             adc_freeze,
  input  logic [CW-1:0]    adc_fchannel,
  output logic             adc_convert,
  output logic [CW-1:0]    adc_channel,
  output logic             adc_sample,
  output logic [CW-1:0]    sample_channel,
  output logic             seq_busy
);

  localparam logic [CW-1:0] CAL_IDX = CW'(CAL_CH);
  localparam logic [CW-1:0] MAX_IDX = CW'(NCH - 1);

  seq_state_e       state_q, state_d;
  logic [CW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    target_q, target_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic             frozen_q, frozen_d;
  logic [CW-1:0]    frozen_ch_q, frozen_ch_d;
  logic             convert_q, convert_d;
  logic [CW-1:0]    channel_q, channel_d;
  logic             sample_q, sample_d;
  logic [CW-1:0]    sample_ch_q, sample_ch_d;
  logic             busy_q, busy_d;

  logic [CW-1:0]    pick_idx_s;
  logic             pick_none_s;
  logic [CW-1:0]    fch_clip_s;

  adc_rr_pick #(.NCH(NCH)) u_pick (
    .mask_i (ch_mask),
    .ptr_i  (ptr_q),
    .idx_o  (pick_idx_s),
    .none_o (pick_none_s)
  );

  // Requested freeze channels beyond the last analog input saturate.
  always_comb begin
    if (int'(adc_fchannel) > (NCH - 1)) begin
      fch_clip_s = MAX_IDX;
    end else begin
      fch_clip_s = adc_fchannel;
    end
  end

  // Next-state logic; outputs are derived from the next state so they line up with it.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    target_d    = target_q;
    cnt_d       = cnt_q;
    frozen_d    = frozen_q;
    frozen_ch_d = frozen_ch_q;

    case (state_q)
      ST_IDLE: begin
        if (sys_ready && (|ch_mask)) begin
          state_d = ST_PARK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PARK: begin
        target_d = frozen_q ? frozen_ch_q : pick_idx_s;
        cnt_d    = settle_cycles;
        if (!sys_ready || (!frozen_q && pick_none_s)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!sys_ready) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_CONVERT;
        end else begin
          cnt_d = cnt_q - DLY_W'(1);
        end
      end
      ST_CONVERT: begin
        if (adc_ready) begin
          state_d = ST_SAMPLE;
        end else begin
          state_d = ST_CONVERT;
        end
      end
      ST_SAMPLE: begin
        // While frozen the pointer holds, so release resumes after the last rotated channel.
        if (!frozen_q) begin
          ptr_d = target_q;
        end else begin
          ptr_d = ptr_q;
        end
        frozen_d = adc_freeze;
        if (adc_freeze) begin
          frozen_ch_d = fch_clip_s;
        end else begin
          frozen_ch_d = frozen_ch_q;
        end
        state_d = sys_ready ? ST_PARK : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    convert_d = (state_d == ST_CONVERT);
    sample_d  = (state_d == ST_SAMPLE);
    busy_d    = (state_d != ST_IDLE);
    case (state_d)
      ST_SETTLE, ST_CONVERT, ST_SAMPLE: channel_d = target_d;
      default:                          channel_d = CAL_IDX;
    endcase
    if (state_d == ST_SAMPLE) begin
      sample_ch_d = target_d;
    end else begin
      sample_ch_d = sample_ch_q;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge SCK or posedge POR) begin
    if (POR) begin
      state_q     <= ST_IDLE;
      ptr_q       <= MAX_IDX;
      target_q    <= CAL_IDX;
      cnt_q       <= '0;
      frozen_q    <= 1'b0;
      frozen_ch_q <= '0;
      convert_q   <= 1'b0;
      channel_q   <= CAL_IDX;
      sample_q    <= 1'b0;
      sample_ch_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      target_q    <= target_d;
      cnt_q       <= cnt_d;
      frozen_q    <= frozen_d;
      frozen_ch_q <= frozen_ch_d;
      convert_q   <= convert_d;
      channel_q   <= channel_d;
      sample_q    <= sample_d;
      sample_ch_q <= sample_ch_d;
      busy_q      <= busy_d;
    end
  end

  assign adc_convert    = convert_q;
  assign adc_channel    = channel_q;
  assign adc_sample     = sample_q;
  assign sample_channel = sample_ch_q;
  assign seq_busy       = busy_q;

endmodule

// File: tb/tb_adc_sequencer.sv
// Scoreboard bench for adc_sequencer: expected sample channels are queued as
// stimulus is driven and popped on every adc_sample pulse.
module tb_adc_sequencer;

  localparam int NCH   = 8;
  localparam int DLY_W = 8;
  localparam int CW    = 3;
  localparam int CAL   = 0;

  logic             SCK = 1'b0;
  logic             POR = 1'b1;
  logic             sys_ready = 1'b0;
  logic [NCH-1:0]   ch_mask = '0;
  logic [DLY_W-1:0] settle_cycles = 8'd2;
  logic             adc_ready = 1'b0;
  logic             adc_freeze = 1'b0;
  logic [CW-1:0]    adc_fchannel = '0;
  logic             adc_convert;
  logic [CW-1:0]    adc_channel;
  logic             adc_sample;
  logic [CW-1:0]    sample_channel;
  logic             seq_busy;

  adc_sequencer #(.NCH(NCH), .DLY_W(DLY_W), .CAL_CH(CAL)) dut (
    .SCK            (SCK),
    .POR            (POR),
    .sys_ready      (sys_ready),
    .ch_mask        (ch_mask),
    .settle_cycles  (settle_cycles),
    .adc_ready      (adc_ready),
    .adc_freeze     (adc_freeze),
    .adc_fchannel   (adc_fchannel),
    .adc_convert    (adc_convert),
    .adc_channel    (adc_channel),
    .adc_sample     (adc_sample),
    .sample_channel (sample_channel),
    .seq_busy       (seq_busy)
  );

  always #5 SCK = ~SCK;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int cyc = 0;
  int last_cyc = -1;
  int interval_exp = 0;
  int ready_delay = 1;
  bit after_sample = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_cmp++;
    if (obs != exp_v) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // ADC model: raise adc_ready after ready_delay cycles of adc_convert.
  initial begin
    int k;
    k = 0;
    forever begin
      @(negedge SCK);
      if (adc_convert) begin
        k++;
        adc_ready = (k >= ready_delay);
      end else begin
        k = 0;
        adc_ready = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on each sample, checks park slot and spacing.
  initial begin
    forever begin
      @(negedge SCK);
      cyc++;
      if (after_sample) chk("park_ch", int'(adc_channel), CAL);
      after_sample = adc_sample;
      if (adc_sample) begin
        if (exp_q.size() == 0) chk("unexpected_sample", int'(sample_channel), -1);
        else chk("sample_ch", int'(sample_channel), exp_q.pop_front());
        if (interval_exp != 0 && last_cyc >= 0) chk("interval", cyc - last_cyc, interval_exp);
        last_cyc = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge SCK);
      #1;
    end
  endtask

  task automatic drain(input int budget);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      tick(1);
      t++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic wait_convert(input int budget);
    int t;
    t = 0;
    while (!adc_convert && t < budget) begin
      tick(1);
      t++;
    end
    chk("convert_seen", int'(adc_convert), 1);
  endtask

  task automatic stop_seq();
    sys_ready = 1'b0;
    tick(2);
    chk("idle_after_stop", int'(seq_busy), 0);
  endtask

  initial begin
    int conv_seen;
    tick(3);
    chk("por_convert", int'(adc_convert), 0);
    chk("por_sample", int'(adc_sample), 0);
    chk("por_channel", int'(adc_channel), CAL);
    chk("por_busy", int'(seq_busy), 0);
    chk("por_sample_ch", int'(sample_channel), 0);
    POR = 1'b0;
    tick(2);

    // Full rotation, settle=2, ready on first CONVERT cycle.
    ch_mask = 8'hFF; settle_cycles = 8'd2; ready_delay = 1;
    interval_exp = 6; last_cyc = -1;
    for (int i = 0; i < 8; i++) exp_q.push_back(i);
    exp_q.push_back(0);
    sys_ready = 1'b1;
    drain(200);
    stop_seq();

    // Sparse mask, then mask change during SETTLE of ch5.
    ch_mask = 8'b1010_0100; last_cyc = -1;
    exp_q.push_back(2); exp_q.push_back(5); exp_q.push_back(7); exp_q.push_back(2);
    sys_ready = 1'b1;
    drain(100);
    tick(2);
    chk("settle_ch5", int'(adc_channel), 5);
    ch_mask = 8'h01;
    exp_q.push_back(5); exp_q.push_back(0);
    drain(50);
    stop_seq();

    // Freeze onto ch3 at the sample of ch1, then release.
    ch_mask = 8'hFF; last_cyc = -1;
    exp_q.push_back(1);
    sys_ready = 1'b1;
    drain(50);
    adc_freeze = 1'b1; adc_fchannel = 3'd3;
    exp_q.push_back(3); exp_q.push_back(3); exp_q.push_back(3);
    drain(60);
    adc_freeze = 1'b0;
    exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4);
    drain(60);
    stop_seq();

    // sys_ready drop during SETTLE: no convert.
    interval_exp = 0;
    sys_ready = 1'b1;
    tick(1);
    chk("park_busy", int'(seq_busy), 1);
    tick(1);
    chk("settle_ch_drop", int'(adc_channel), 5);
    sys_ready = 1'b0;
    tick(1);
    chk("idle_after_settle_drop", int'(seq_busy), 0);
    conv_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (adc_convert) conv_seen = 1;
    end
    chk("no_convert", conv_seen, 0);

    // sys_ready drop during CONVERT: conversion completes, one sample, then IDLE.
    ready_delay = 5;
    exp_q.push_back(5);
    sys_ready = 1'b1;
    wait_convert(20);
    sys_ready = 1'b0;
    drain(30);
    tick(1);
    chk("idle_after_convert_drop", int'(seq_busy), 0);

    // Empty mask keeps the sequencer idle.
    ch_mask = 8'h00; ready_delay = 1;
    sys_ready = 1'b1;
    tick(5);
    chk("mask0_busy", int'(seq_busy), 0);
    chk("mask0_convert", int'(adc_convert), 0);
    sys_ready = 1'b0;

    // settle=0: one SETTLE cycle, 4 cycles per conversion.
    ch_mask = 8'hFF; settle_cycles = 8'd0;
    interval_exp = 4; last_cyc = -1;
    exp_q.push_back(6); exp_q.push_back(7); exp_q.push_back(0);
    sys_ready = 1'b1;
    drain(60);
    stop_seq();

    // POR mid-CONVERT.
    settle_cycles = 8'd2; ready_delay = 100; interval_exp = 0;
    sys_ready = 1'b1;
    wait_convert(20);
    POR = 1'b1;
    @(posedge SCK);
    #1;
    chk("rst_convert", int'(adc_convert), 0);
    chk("rst_sample", int'(adc_sample), 0);
    chk("rst_channel", int'(adc_channel), CAL);
    chk("rst_busy", int'(seq_busy), 0);
    sys_ready = 1'b0; ready_delay = 1;
    POR = 1'b0;
    tick(2);

    // Pointer is back at NCH-1, so rotation restarts at ch0.
    last_cyc = -1;
    exp_q.push_back(0);
    sys_ready = 1'b1;
    drain(50);
    stop_seq();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
